// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Brief    : RV32I IF stage: PC register, PC+4 adder, IF/ID pipeline register.
//            Optional macro FETCH_MISALIGN_TRAP_EN enables misaligned-PC trapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_next,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_plus4,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] id_instr,
  output logic        id_valid,
  output logic [31:0] fetch_cnt,
  output logic        misalign_err
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        advance;

  assign pc_plus4  = pc_q + 32'd4;
  assign imem_addr = pc_q;
  // Flush redirects the PC even while the hazard unit requests a stall.
  assign advance   = flush | ~stall;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_err_q, misalign_err_d;
  logic misaligned;

  assign misaligned = (pc_next[1:0] != 2'b00);

  always_comb begin
    pc_d           = pc_q;
    id_pc_d        = id_pc_q;
    id_pc_plus4_d  = id_pc_plus4_q;
    id_instr_d     = id_instr_q;
    id_valid_d     = id_valid_q;
    fetch_cnt_d    = fetch_cnt_q;
    misalign_err_d = misalign_err_q;
    if (advance) begin
      if (misaligned || flush) begin
        id_pc_d       = 32'd0;
        id_pc_plus4_d = 32'd0;
        id_instr_d    = NOP_INSTR;
        id_valid_d    = 1'b0;
      end else begin
        id_pc_d       = pc_q;
        id_pc_plus4_d = pc_plus4;
        id_instr_d    = imem_rdata;
        id_valid_d    = 1'b1;
        fetch_cnt_d   = fetch_cnt_q + 32'd1;
      end
      if (misaligned) begin
        misalign_err_d = 1'b1;
      end else begin
        pc_d = pc_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_err_q <= 1'b0;
    end else begin
      misalign_err_q <= misalign_err_d;
    end
  end

  assign misalign_err = misalign_err_q;
`else
  always_comb begin
    pc_d          = pc_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_instr_d    = id_instr_q;
    id_valid_d    = id_valid_q;
    fetch_cnt_d   = fetch_cnt_q;
    if (advance) begin
      // Low address bits are dropped so the PC is always word aligned.
      pc_d = pc_next & ~32'd3;
      if (flush) begin
        id_pc_d       = 32'd0;
        id_pc_plus4_d = 32'd0;
        id_instr_d    = NOP_INSTR;
        id_valid_d    = 1'b0;
      end else begin
        id_pc_d       = pc_q;
        id_pc_plus4_d = pc_plus4;
        id_instr_d    = imem_rdata;
        id_valid_d    = 1'b1;
        fetch_cnt_d   = fetch_cnt_q + 32'd1;
      end
    end
  end

  assign misalign_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      id_pc_q       <= 32'd0;
      id_pc_plus4_q <= 32'd0;
      id_instr_q    <= NOP_INSTR;
      id_valid_q    <= 1'b0;
      fetch_cnt_q   <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_instr_q    <= id_instr_d;
      id_valid_q    <= id_valid_d;
      fetch_cnt_q   <= fetch_cnt_d;
    end
  end

  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign id_instr    = id_instr_q;
  assign id_valid    = id_valid_q;
  assign fetch_cnt   = fetch_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Self-checking bench for fetch_stage (reference model + directed vectors).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_next;
  logic        stall;
  logic        flush;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] pc_plus4;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instr;
  logic        id_valid;
  logic [31:0] fetch_cnt;
  logic        misalign_err;

  logic        use_seq;
  logic [31:0] tgt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: imem_word = 32'h00A0_0093;
      32'h0000_0004: imem_word = 32'h00B0_0113;
      default:       imem_word = {a[23:0], 8'h13};
    endcase
  endfunction

  assign imem_rdata = imem_word(imem_addr);
  assign pc_next    = use_seq ? pc_plus4 : tgt;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .pc_next      (pc_next),
    .stall        (stall),
    .flush        (flush),
    .imem_rdata   (imem_rdata),
    .imem_addr    (imem_addr),
    .pc_plus4     (pc_plus4),
    .id_pc        (id_pc),
    .id_pc_plus4  (id_pc_plus4),
    .id_instr     (id_instr),
    .id_valid     (id_valid),
    .fetch_cnt    (fetch_cnt),
    .misalign_err (misalign_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the architectural state the stage must present.
  logic [31:0] m_pc, m_id_pc, m_id_pc4, m_id_instr, m_cnt;
  logic        m_valid, m_err, m_live;
  logic [31:0] m_tgt;
  initial m_live = 1'b0;

  always @(posedge clk) begin
    m_tgt = use_seq ? (m_pc + 32'd4) : tgt;
    if (reset) begin
      m_pc <= 32'h0; m_id_pc <= 32'h0; m_id_pc4 <= 32'h0;
      m_id_instr <= 32'h13; m_valid <= 1'b0; m_cnt <= 32'h0; m_err <= 1'b0;
      m_live <= 1'b1;
    end else if (flush || !stall) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (m_tgt % 4 != 0) begin
        m_err <= 1'b1;
        m_id_pc <= 32'h0; m_id_pc4 <= 32'h0; m_id_instr <= 32'h13; m_valid <= 1'b0;
      end else begin
        m_pc <= m_tgt;
`else
      begin
        m_pc <= (m_tgt / 4) * 4;
`endif
        if (flush) begin
          m_id_pc <= 32'h0; m_id_pc4 <= 32'h0; m_id_instr <= 32'h13; m_valid <= 1'b0;
        end else begin
          m_id_pc <= m_pc; m_id_pc4 <= m_pc + 32'd4;
          m_id_instr <= imem_word(m_pc); m_valid <= 1'b1; m_cnt <= m_cnt + 32'd1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("m_imem_addr", imem_addr, m_pc);
      check("m_pc_plus4", pc_plus4, m_pc + 32'd4);
      check("m_id_pc", id_pc, m_id_pc);
      check("m_id_pc_plus4", id_pc_plus4, m_id_pc4);
      check("m_id_instr", id_instr, m_id_instr);
      check("m_id_valid", {31'd0, id_valid}, {31'd0, m_valid});
      check("m_fetch_cnt", fetch_cnt, m_cnt);
      check("m_misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; use_seq = 1'b1; tgt = 32'h0;
    tick(); tick();
    reset = 1'b0;
    probe();
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_id_valid", {31'd0, id_valid}, 32'd0);
    check("rst_id_instr", id_instr, 32'h0000_0013);
    check("rst_fetch_cnt", fetch_cnt, 32'd0);

    tick(); probe();
    check("seq1_id_pc", id_pc, 32'h0);
    check("seq1_id_instr", id_instr, 32'h00A0_0093);
    check("seq1_id_valid", {31'd0, id_valid}, 32'd1);
    tick(); probe();
    check("seq2_id_pc", id_pc, 32'h4);
    check("seq2_id_pc_plus4", id_pc_plus4, 32'h8);
    check("seq2_fetch_cnt", fetch_cnt, 32'd2);
    check("seq2_id_instr", id_instr, 32'h00B0_0113);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); probe();
      check("stall_imem_addr", imem_addr, 32'h8);
      check("stall_id_pc", id_pc, 32'h4);
      check("stall_fetch_cnt", fetch_cnt, 32'd2);
    end
    stall = 1'b0;
    tick(); probe();
    check("unstall_id_pc", id_pc, 32'h8);
    check("unstall_fetch_cnt", fetch_cnt, 32'd3);
    check("unstall_imem_addr", imem_addr, 32'hC);

    stall = 1'b1; flush = 1'b1; use_seq = 1'b0; tgt = 32'h40;
    tick(); probe();
    check("flush_imem_addr", imem_addr, 32'h40);
    check("flush_id_valid", {31'd0, id_valid}, 32'd0);
    check("flush_id_instr", id_instr, 32'h13);
    check("flush_fetch_cnt", fetch_cnt, 32'd3);
    stall = 1'b0; flush = 1'b0; use_seq = 1'b1;
    tick(); tick(); probe();
    check("post_flush_id_pc", id_pc, 32'h44);

    use_seq = 1'b0; tgt = 32'hFFFF_FFFC;
    tick(); probe();
    check("wrap_pc_plus4", pc_plus4, 32'h0);
    use_seq = 1'b1;
    tick(); probe();
    check("wrap_imem_addr", imem_addr, 32'h0);
    check("wrap_id_pc_plus4", id_pc_plus4, 32'h0);
    check("wrap_id_pc", id_pc, 32'hFFFF_FFFC);

    use_seq = 1'b0; tgt = 32'h0000_0022;
    tick(); probe();
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_imem_addr", imem_addr, 32'h0);
    check("mis_err", {31'd0, misalign_err}, 32'd1);
    check("mis_id_valid", {31'd0, id_valid}, 32'd0);
    use_seq = 1'b1;
    tick(); tick(); probe();
    check("mis_err_sticky", {31'd0, misalign_err}, 32'd1);
`else
    check("mis_imem_addr", imem_addr, 32'h20);
    check("mis_err", {31'd0, misalign_err}, 32'd0);
    use_seq = 1'b1;
    tick(); probe();
    check("mis_next_addr", imem_addr, 32'h24);
`endif

    reset = 1'b1; stall = 1'b1; flush = 1'b1; use_seq = 1'b0; tgt = 32'h80;
    tick(); probe();
    check("rst_ovr_imem_addr", imem_addr, 32'h0);
    check("rst_ovr_id_valid", {31'd0, id_valid}, 32'd0);
    check("rst_ovr_fetch_cnt", fetch_cnt, 32'd0);
    check("rst_ovr_err", {31'd0, misalign_err}, 32'd0);
    reset = 1'b0; stall = 1'b0; flush = 1'b0; use_seq = 1'b1;
    tick(); tick(); probe();
    check("rerun_id_pc", id_pc, 32'h4);
    check("rerun_fetch_cnt", fetch_cnt, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
